// File: rtl/seq_detector_prog.sv
// seq_detector_prog
// Runtime-programmable serial sequence detector with selectable overlapping /
// non-overlapping detection, a Mealy match flag, a registered copy of it and a
// saturating match counter. The pattern can be reloaded at any time without a
// reset.
//
// Parameters:
//   LEN          pattern length in bits (LEN >= 2)
//   CNT_W        width of the match counter
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset, highest priority
//   load         capture pattern_in, restart history
//   pattern_in   pattern; bit LEN-1 is received first, bit 0 last
//   overlap      1 = overlapping detection, 0 = non-overlapping
//   in_valid     qualifies in_seq
//   in_seq       serial data bit
//   out_seq      combinational match flag for the current bit
//   match_q      out_seq delayed by one cycle
//   match_count  number of matches, saturating at all-ones
module seq_detector_prog #(
  parameter int LEN   = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [LEN-1:0]   pattern_in,
  input  logic             overlap,
  input  logic             in_valid,
  input  logic             in_seq,
  output logic             out_seq,
  output logic             match_q,
  output logic [CNT_W-1:0] match_count
);

  localparam int FW = (LEN > 2) ? $clog2(LEN) : 1;
  localparam logic [FW-1:0] FILL_FULL = FW'(LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HUNT = 2'd2
  } state_t;

  state_t         state, state_next;
  logic [LEN-1:0] pat,   pat_next;
  logic [LEN-2:0] hist,  hist_next;
  logic [FW-1:0]  fill,  fill_next;

  logic           accept;
  logic           match;
  logic [LEN-1:0] window;

  // Window of the last LEN-1 accepted bits plus the bit on the wire; its low
  // LEN-1 bits are also the shifted history, which keeps LEN = 2 legal.
  assign window = {hist, in_seq};
  assign accept = in_valid & ~load & (state != IDLE);
  assign match  = (window == pat);

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    pat_next   = pat;
    hist_next  = hist;
    fill_next  = fill;
    out_seq    = 1'b0;

    if (load) begin
      // A bit arriving with load is discarded; the new pattern starts clean.
      pat_next   = pattern_in;
      hist_next  = '0;
      fill_next  = '0;
      state_next = FILL;
    end else if (accept) begin
      unique case (state)
        FILL: begin
          hist_next = window[LEN-2:0];
          fill_next = fill + 1'b1;
          if (fill + 1'b1 == FILL_FULL) state_next = HUNT;
        end
        HUNT: begin
          out_seq = match;
          if (match && !overlap) begin
            // Non-overlapping: matched bits are not reused.
            hist_next  = '0;
            fill_next  = '0;
            state_next = FILL;
          end else begin
            hist_next = window[LEN-2:0];
          end
        end
        default: ;
      endcase
    end

    if (reset) out_seq = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pat         <= '0;
      hist        <= '0;
      fill        <= '0;
      match_q     <= 1'b0;
      match_count <= '0;
    end else begin
      state   <= state_next;
      pat     <= pat_next;
      hist    <= hist_next;
      fill    <= fill_next;
      match_q <= out_seq;
      if (out_seq && (match_count != '1)) match_count <= match_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_detector_prog.sv
// Self-checking bench for seq_detector_prog. Two instances share one stimulus:
// the default 8-bit counter and a 2-bit counter for saturation. A queue-based
// model of the accepted bit stream predicts every output each cycle; directed
// sections also carry hand-computed literal expectations.
module tb_seq_detector_prog;

  localparam int LEN = 4;

  logic           clk = 1'b0;
  logic           reset, load, overlap, in_valid, in_seq;
  logic [LEN-1:0] pattern_in;
  logic           out_seq, match_q, out_seq_s, match_q_s;
  logic [7:0]     match_count;
  logic [1:0]     match_count_s;

  int checks   = 0;
  int failures = 0;

  // Model state: accepted bits since the last restart, oldest first.
  bit             m_loaded;
  bit             m_q[$];
  logic [LEN-1:0] m_pat;
  bit             m_mq;
  int             m_cnt8, m_cnt2;

  always #5 clk = ~clk;

  seq_detector_prog #(.LEN(LEN), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .load(load), .pattern_in(pattern_in),
    .overlap(overlap), .in_valid(in_valid), .in_seq(in_seq),
    .out_seq(out_seq), .match_q(match_q), .match_count(match_count)
  );

  seq_detector_prog #(.LEN(LEN), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .load(load), .pattern_in(pattern_in),
    .overlap(overlap), .in_valid(in_valid), .in_seq(in_seq),
    .out_seq(out_seq_s), .match_q(match_q_s), .match_count(match_count_s)
  );

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Expected Mealy output: the last LEN-1 accepted bits followed by the
  // current bit must spell the pattern, first bit at the MSB.
  function automatic bit model_match(input bit v, input bit b, input bit ld, input bit r);
    logic [LEN-1:0] w;
    if (r || ld || !v || !m_loaded || m_q.size() != LEN - 1) return 1'b0;
    for (int i = 0; i < LEN - 1; i++) w[LEN-1-i] = m_q[i];
    w[0] = b;
    return w == m_pat;
  endfunction

  // One clock: drive at negedge, compare 1 ns later, advance the model at the
  // edge. lit = -1 means no literal expectation for out_seq.
  task automatic step(input bit r, input bit ld, input logic [LEN-1:0] p,
                      input bit ov, input bit v, input bit b, input int lit);
    bit exp_out;
    reset = r; load = ld; pattern_in = p; overlap = ov; in_valid = v; in_seq = b;
    #1;
    exp_out = model_match(v, b, ld, r);
    check("out_seq", int'(out_seq), int'(exp_out));
    check("out_seq_sat", int'(out_seq_s), int'(exp_out));
    check("match_q", int'(match_q), int'(m_mq));
    check("match_count", int'(match_count), m_cnt8);
    check("match_count_sat", int'(match_count_s), m_cnt2);
    if (lit >= 0) check("out_seq_literal", int'(out_seq), lit);
    @(posedge clk);
    if (r) begin
      m_loaded = 1'b0; m_q.delete(); m_pat = '0; m_mq = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
    end else begin
      m_mq = exp_out;
      if (exp_out) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (ld) begin
        m_pat = p; m_loaded = 1'b1; m_q.delete();
      end else if (m_loaded && v) begin
        if (exp_out && !ov) m_q.delete();
        else begin
          m_q.push_back(b);
          if (m_q.size() > LEN - 1) void'(m_q.pop_front());
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input bit ov, input bit b, input int lit);
    step(1'b0, 1'b0, '0, ov, 1'b1, b, lit);
  endtask

  task automatic do_load(input logic [LEN-1:0] p);
    step(1'b0, 1'b1, p, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic idle(input int lit);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, lit);
  endtask

  initial begin
    bit seq_a[7]  = '{1, 0, 0, 1, 0, 0, 1};
    int ovl_a[7]  = '{0, 0, 0, 1, 0, 0, 1};
    int novl_a[7] = '{0, 0, 0, 1, 0, 0, 0};
    int sat_a[5]  = '{1, 2, 3, 3, 3};
    bit gap_a[4]  = '{1, 0, 0, 1};
    bit rl_a[4]   = '{0, 1, 1, 0};

    reset = 1'b1; load = 1'b0; pattern_in = '0; overlap = 1'b0;
    in_valid = 1'b0; in_seq = 1'b0;
    m_loaded = 1'b0; m_pat = '0; m_mq = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
    @(negedge clk);

    // Reset, then IDLE ignores valid bits.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1, 0);
    for (int i = 0; i < 12; i++) send(1'b1, 1'($urandom), 0);
    check("idle_match_q", int'(match_q), 0);
    check("idle_count", int'(match_count), 0);

    // Overlap mode.
    do_load(4'b1001);
    for (int i = 0; i < 7; i++) send(1'b1, seq_a[i], ovl_a[i]);
    check("ovl_match_q", int'(match_q), 1);
    idle(0);
    check("ovl_count", int'(match_count), 2);

    // Non-overlap mode (counter keeps its value across load).
    do_load(4'b1001);
    for (int i = 0; i < 7; i++) send(1'b0, seq_a[i], novl_a[i]);
    idle(0);
    check("novl_count", int'(match_count), 3);

    // Valid gaps.
    do_load(4'b1001);
    for (int i = 0; i < 4; i++) begin
      send(1'b1, gap_a[i], (i == 3) ? 1 : 0);
      if (i < 3) for (int g = 0; g < 3; g++) idle(0);
    end
    check("gap_match_q", int'(match_q), 1);
    idle(0);
    check("gap_count", int'(match_count), 4);

    // Saturation on the 2-bit counter, from a fresh reset.
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 0);
    do_load(4'b1111);
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 1'b1, (i >= 3) ? 1 : 0);
      if (i >= 3) check("sat_count", int'(match_count_s), sat_a[i-3]);
    end
    check("sat_count8", int'(match_count), 5);

    // Reload mid-stream: the bit with load is discarded.
    do_load(4'b1001);
    send(1'b1, 1'b1, 0); send(1'b1, 1'b0, 0); send(1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 4'b0110, 1'b1, 1'b1, 1'b1, 0);
    for (int i = 0; i < 4; i++) send(1'b1, rl_a[i], (i == 3) ? 1 : 0);

    // Reset on the cycle before the completing bit, then back in IDLE.
    do_load(4'b1001);
    send(1'b1, 1'b1, 0); send(1'b1, 1'b0, 0); send(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b1, 0);
    send(1'b1, 1'b1, 0);
    for (int i = 0; i < 6; i++) send(1'b1, 1'($urandom), 0);
    check("rst_count", int'(match_count), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bit r  = ($urandom_range(0, 99) == 0);
      bit ld = ($urandom_range(0, 29) == 0);
      step(r, ld, LEN'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
           1'($urandom), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/seq_detector_prog.md
# seq_detector_prog

Runtime-programmable serial sequence detector, parametrised in pattern length, with selectable overlapping/non-overlapping detection, a Mealy match output plus a registered copy, and a saturating match counter. It generalises the team's fixed-pattern Mealy detectors. It sits on a single-bit serial stream with a qualifying valid strobe, and its pattern can be reloaded without a reset.

## Interface
- `LEN`, default 4: pattern length in bits; legal range `LEN >= 2`.
- `CNT_W`, default 8: width of the match counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `load`  in  1  when high, captures `pattern_in` at the clock edge.
- `pattern_in`  in  LEN  pattern to load. `pattern_in[LEN-1]` is the first bit received; `pattern_in[0]` is the last.
- `overlap`  in  1  detection mode: 1 = overlapping, 0 = non-overlapping. Sampled every cycle.
- `in_valid`  in  1  qualifies `in_seq`. When low, the cycle is ignored.
- `in_seq`  in  1  serial data bit.
- `out_seq`  out  1  combinational Mealy match flag, valid in the same cycle as the completing bit.
- `match_q`  out  1  `out_seq` registered; one-cycle pulse.
- `match_count`  out  CNT_W  number of matches, saturating at all-ones.

## Operation
- **Internal state**
  - `pat`: LEN-bit pattern register.
  - `hist`: the last LEN-1 accepted bits, newest bit in `hist[0]`.
  - `fill`: count of valid history bits, range 0..LEN-1.
  - `state`: one of IDLE, FILL, HUNT.
- **IDLE.** No pattern loaded yet. Entered on reset. `in_valid` is ignored. `load` moves the block to FILL.
- **FILL.** Entered when `fill < LEN-1`. Each accepted bit shifts into `hist` and increments `fill`. When `fill` reaches LEN-1, the state becomes HUNT.
- **HUNT.** Entered when `fill == LEN-1`.
  - The block computes `match = ({hist[LEN-2:0], in_seq} == pat)`.
  - `out_seq = in_valid & match & ~load`.
- **Accepted bit.** A bit is accepted when `in_valid = 1`, `load = 0`, and the state is not IDLE.
- **On a match**, behaviour depends on `overlap`:
  - `overlap = 1`: the bit shifts into `hist` and the state stays HUNT.
  - `overlap = 0`: `hist` clears, `fill` becomes 0, and the state becomes FILL. The matched bits are not reused.
- **No match in HUNT:** the bit shifts into `hist` and the state stays HUNT (sliding window).
- **`load = 1`** in any state:
  - `pat <= pattern_in`.
  - `hist` clears, `fill` becomes 0, and the state becomes FILL.
  - A simultaneous `in_valid` bit is discarded and `out_seq = 0`.
  - `match_count` is not cleared.
- **`match_count`** increments at the edge where `out_seq = 1`, unless it is already all-ones.
- **`reset = 1`** has priority over everything, including `load`. It sets:
  - state IDLE;
  - `pat`, `hist`, `fill` to 0;
  - `match_q` to 0 and `match_count` to 0.
- **Combinational outputs under reset:** `out_seq` is forced to 0 while `reset = 1`, and is 0 in IDLE and FILL.

## Timing
- **Latency.** `out_seq` is asserted in the same cycle as the completing valid bit, with zero latency. `match_q` follows one cycle later and lasts exactly one cycle per match.
- **Reset values:** `out_seq = 0`, `match_q = 0`, `match_count = 0`.
- **First possible match** is on the LEN-th accepted bit after reset, load, or a non-overlap match.
- **`in_valid` low** holds `hist`, `fill`, state and `match_count` unchanged. `match_q` still updates, so it becomes 0.
- **`overlap` change** takes effect on the very next match. It never alters history already captured.
- **Reset mid-stream:** the block returns to IDLE on the next edge. A pattern must be reloaded before any further detection.
- **Back-to-back matches** are possible in overlap mode, e.g. pattern 1111 on an all-ones stream gives `out_seq` high every valid cycle.

## Test plan
- **Reset and IDLE.** Hold `reset` for 3 cycles, then drive `in_valid = 1` with random bits and no load. Required: `out_seq = match_q = 0` and `match_count = 0` throughout.
- **Overlap mode.** LEN = 4, load 4'b1001, `overlap = 1`, stream 1,0,0,1,0,0,1. Required: `out_seq` high on the 4th and 7th bits, `match_q` high one cycle after each, final `match_count = 2`.
- **Non-overlap mode.** Same load and stream with `overlap = 0`. Required: `out_seq` high on the 4th bit only, final `match_count = 1`.
- **Valid gaps.** Stream 1,0,0,1 with `in_valid` low for 3 cycles between each bit. Required: a single `out_seq` pulse coincident with the final valid bit, and no pulses during the gaps.
- **Saturation.** CNT_W = 2, pattern 4'b1111, `overlap = 1`, 8 consecutive valid ones. Required: 5 matches; `match_count` reads 1, 2, 3, 3, 3 after each match edge.
- **Reload and reset mid-stream.**
  - After 3 bits of 1,0,0, assert `load` with 4'b0110 together with a valid 1. Required: that bit is ignored; the stream 0,1,1,0 then matches once on its last bit.
  - Assert `reset` on the cycle before a completing bit. Required: no match, and the state returns to IDLE.
